// File: rtl/ad_cmos_cal_pkg.sv
// Shared types and helpers for the CMOS ADC IDELAY tap calibration block.
package ad_cmos_cal_pkg;

  localparam int TAP_WIDTH_DEF = 5;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT_LOCK,
    ST_LOAD,
    ST_SETTLE,
    ST_CLEAR,
    ST_DWELL,
    ST_EVAL,
    ST_CENTER,
    ST_APPLY,
    ST_DONE
  } cal_state_e;

  // A window can span every tap, so it needs one bit more than a tap value.
  function automatic int win_w(input int tap_width);
    return tap_width + 1;
  endfunction

endpackage

// File: rtl/ad_idelay_win_track.sv
// Per-lane passing-window tracker: follows the current run of passing taps and
// keeps the longest closed run (earliest one on ties) plus its centre tap.
module ad_idelay_win_track
  import ad_cmos_cal_pkg::*;
#(
  parameter int TAP_WIDTH = TAP_WIDTH_DEF
) (
  input  logic                 up_clk,
  input  logic                 up_rstn,
  input  logic                 clr,
  input  logic                 eval,
  input  logic                 pass,
  input  logic [TAP_WIDTH-1:0] tap,
  input  logic                 last,
  output logic [TAP_WIDTH-1:0] best_start,
  output logic [TAP_WIDTH:0]   best_len,
  output logic [TAP_WIDTH-1:0] centre
);

  localparam int WW = win_w(TAP_WIDTH);

  logic [TAP_WIDTH-1:0] cur_start_q, cur_start_d;
  logic [WW-1:0]        cur_len_q, cur_len_d;
  logic [TAP_WIDTH-1:0] best_start_q, best_start_d;
  logic [WW-1:0]        best_len_q, best_len_d;
  logic [TAP_WIDTH-1:0] cand_start;
  logic [WW-1:0]        cand_len;
  logic                 close_run;

  always_comb begin
    cur_start_d  = cur_start_q;
    cur_len_d    = cur_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    cand_start   = cur_start_q;
    cand_len     = cur_len_q;
    close_run    = 1'b0;
    if (clr) begin
      cur_start_d  = '0;
      cur_len_d    = '0;
      best_start_d = '0;
      best_len_d   = '0;
    end else if (eval) begin
      if (pass) begin
        cur_len_d = cur_len_q + 1'b1;
        if (cur_len_q == '0) cur_start_d = tap;
        cand_start = cur_start_d;
        cand_len   = cur_len_d;
        close_run  = last;
      end else begin
        cur_len_d = '0;
        close_run = 1'b1;
      end
      // Strictly longer only: an equal later run never displaces the earlier one.
      if (close_run && (cand_len > best_len_q)) begin
        best_start_d = cand_start;
        best_len_d   = cand_len;
      end
      if (last) cur_len_d = '0;
    end
  end

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      cur_start_q  <= '0;
      cur_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
    end else begin
      cur_start_q  <= cur_start_d;
      cur_len_q    <= cur_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
    end
  end

  assign best_start = best_start_q;
  assign best_len   = best_len_q;
  assign centre     = best_start_q + TAP_WIDTH'(best_len_q >> 1);

endmodule

// File: rtl/ad_data_in_cmos_cal.sv
// IDELAY tap calibration controller: sweeps all lane taps in parallel, scores
// them from the sticky pattern-error flags and loads each lane's window centre.
module ad_data_in_cmos_cal
  import ad_cmos_cal_pkg::*;
#(
  parameter int NUM_LANES     = 8,
  parameter int TAP_WIDTH     = TAP_WIDTH_DEF,
  parameter int SETTLE_CYCLES = 16,
  parameter int DWELL_CYCLES  = 1024,
  parameter int MIN_WINDOW    = 4
) (
  input  logic                                 up_clk,
  input  logic                                 up_rstn,
  input  logic                                 delay_locked,
  input  logic                                 cal_start,
  output logic                                 cal_busy,
  output logic                                 cal_done,
  output logic [NUM_LANES-1:0]                 cal_lane_fail,
  output logic [NUM_LANES-1:0][TAP_WIDTH:0]    cal_lane_win,
  input  logic [NUM_LANES-1:0]                 man_dld,
  input  logic [NUM_LANES-1:0][TAP_WIDTH-1:0]  man_dwdata,
  input  logic [NUM_LANES-1:0]                 adc_err,
  output logic                                 adc_err_clr,
  output logic [NUM_LANES-1:0]                 up_dld,
  output logic [NUM_LANES-1:0][TAP_WIDTH-1:0]  up_dwdata
);

  localparam int WW      = win_w(TAP_WIDTH);
  localparam int CNT_MAX = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  cal_state_e                          state_q;
  logic [TAP_WIDTH-1:0]                tap_q;
  logic [CW-1:0]                       cnt_q;
  logic                                busy_q;
  logic                                done_q;
  logic                                err_clr_q;
  logic [NUM_LANES-1:0]                lane_fail_q;
  logic [NUM_LANES-1:0][WW-1:0]        lane_win_q;
  logic [NUM_LANES-1:0]                dld_q;
  logic [NUM_LANES-1:0][TAP_WIDTH-1:0] dwdata_q;

  logic                                abort;
  logic                                trk_clr;
  logic                                trk_eval;
  logic [NUM_LANES-1:0][WW-1:0]        trk_len;
  logic [NUM_LANES-1:0][TAP_WIDTH-1:0] trk_centre;
  logic [NUM_LANES-1:0]                lane_short;

  // Losing IDELAYCTRL lock invalidates every tap measured so far.
  assign abort    = !delay_locked && (state_q != ST_IDLE) && (state_q != ST_WAIT_LOCK);
  assign trk_clr  = ((state_q == ST_IDLE) && cal_start) || abort;
  assign trk_eval = (state_q == ST_EVAL) && !abort;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    ad_idelay_win_track #(
      .TAP_WIDTH (TAP_WIDTH)
    ) u_trk (
      .up_clk     (up_clk),
      .up_rstn    (up_rstn),
      .clr        (trk_clr),
      .eval       (trk_eval),
      .pass       (!adc_err[g]),
      .tap        (tap_q),
      .last       (&tap_q),
      .best_start (),
      .best_len   (trk_len[g]),
      .centre     (trk_centre[g])
    );
    assign lane_short[g] = trk_len[g] < WW'(MIN_WINDOW);
  end

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      state_q     <= ST_IDLE;
      tap_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_clr_q   <= 1'b0;
      lane_fail_q <= '0;
      lane_win_q  <= '0;
      dld_q       <= '0;
      dwdata_q    <= '0;
    end else begin
      dld_q     <= '0;
      err_clr_q <= 1'b0;
      done_q    <= 1'b0;
      if (abort) begin
        state_q <= ST_WAIT_LOCK;
        tap_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            for (int i = 0; i < NUM_LANES; i++) begin
              if (man_dld[i]) begin
                dld_q[i]    <= 1'b1;
                dwdata_q[i] <= man_dwdata[i];
              end
            end
            if (cal_start) begin
              state_q     <= ST_WAIT_LOCK;
              busy_q      <= 1'b1;
              lane_fail_q <= '0;
              lane_win_q  <= '0;
            end
          end
          ST_WAIT_LOCK: begin
            if (delay_locked) begin
              tap_q   <= '0;
              state_q <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            dld_q <= '1;
            for (int i = 0; i < NUM_LANES; i++) dwdata_q[i] <= tap_q;
            cnt_q   <= CW'(SETTLE_CYCLES - 1);
            state_q <= ST_SETTLE;
          end
          ST_SETTLE: begin
            if (cnt_q == '0) state_q <= ST_CLEAR;
            else             cnt_q   <= cnt_q - 1'b1;
          end
          ST_CLEAR: begin
            err_clr_q <= 1'b1;
            cnt_q     <= CW'(DWELL_CYCLES - 1);
            state_q   <= ST_DWELL;
          end
          ST_DWELL: begin
            if (cnt_q == '0) state_q <= ST_EVAL;
            else             cnt_q   <= cnt_q - 1'b1;
          end
          ST_EVAL: begin
            if (&tap_q) begin
              state_q <= ST_CENTER;
            end else begin
              tap_q   <= tap_q + 1'b1;
              state_q <= ST_LOAD;
            end
          end
          // Trackers absorb the last-tap verdict on the EVAL edge; results are stable here.
          ST_CENTER: state_q <= ST_APPLY;
          ST_APPLY: begin
            dld_q <= '1;
            for (int i = 0; i < NUM_LANES; i++) begin
              dwdata_q[i]    <= lane_short[i] ? '0 : trk_centre[i];
              lane_fail_q[i] <= lane_short[i];
              lane_win_q[i]  <= trk_len[i];
            end
            state_q <= ST_DONE;
          end
          ST_DONE: begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign cal_busy      = busy_q;
  assign cal_done      = done_q;
  assign cal_lane_fail = lane_fail_q;
  assign cal_lane_win  = lane_win_q;
  assign adc_err_clr   = err_clr_q;
  assign up_dld        = dld_q;
  assign up_dwdata     = dwdata_q;

endmodule

// File: tb/tb_ad_data_in_cmos_cal.sv
// Directed bench for the tap calibration controller with a sticky-error ADC model.
module tb_ad_data_in_cmos_cal;

  logic                up_clk = 1'b0;
  logic                up_rstn;
  logic                delay_locked;
  logic                cal_start;
  logic                cal_busy;
  logic                cal_done;
  logic [7:0]          cal_lane_fail;
  logic [7:0][5:0]     cal_lane_win;
  logic [7:0]          man_dld;
  logic [7:0][4:0]     man_dwdata;
  logic [7:0]          adc_err = '0;
  logic                adc_err_clr;
  logic [7:0]          up_dld;
  logic [7:0][4:0]     up_dwdata;

  logic [7:0][31:0]    err_map;
  logic [7:0][4:0]     tb_tap = '0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0][31:0] err;
    logic [7:0][5:0]  win;
    logic [7:0][4:0]  tap;
    logic [7:0]       fail;
  } vec_t;
  vec_t vecs[4];

  always #5 up_clk = ~up_clk;

  ad_data_in_cmos_cal #(
    .NUM_LANES(8), .TAP_WIDTH(5), .SETTLE_CYCLES(4), .DWELL_CYCLES(8), .MIN_WINDOW(4)
  ) dut (
    .up_clk(up_clk), .up_rstn(up_rstn), .delay_locked(delay_locked), .cal_start(cal_start),
    .cal_busy(cal_busy), .cal_done(cal_done), .cal_lane_fail(cal_lane_fail),
    .cal_lane_win(cal_lane_win), .man_dld(man_dld), .man_dwdata(man_dwdata),
    .adc_err(adc_err), .adc_err_clr(adc_err_clr), .up_dld(up_dld), .up_dwdata(up_dwdata)
  );

  // ADC model: each lane's sticky flag sets whenever its currently loaded tap is bad.
  always @(posedge up_clk) begin
    for (int i = 0; i < 8; i++) begin
      if (up_dld[i]) tb_tap[i] <= up_dwdata[i];
      if (adc_err_clr) adc_err[i] <= 1'b0;
      else if (err_map[i][tb_tap[i]]) adc_err[i] <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge up_clk);
    #1;
  endtask

  task automatic pulse_start();
    cal_start = 1'b1;
    cyc();
    cal_start = 1'b0;
  endtask

  task automatic wait_done(output int n_done, output int n_strobe, output int first_tap,
                           output logic tmo);
    n_done = 0; n_strobe = 0; first_tap = -1; tmo = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      cyc();
      if (up_dld == 8'hFF) begin
        if (n_strobe == 0) first_tap = int'(up_dwdata[0]);
        n_strobe++;
      end
      if (cal_done) begin
        n_done++;
        tmo = 1'b0;
        break;
      end
    end
    repeat (3) begin
      cyc();
      if (cal_done) n_done++;
    end
  endtask

  initial begin
    int nd, ns, ft, n;
    logic tmo, found;

    for (int r = 0; r < 4; r++) begin
      vecs[r].err = '0;
      vecs[r].fail = '0;
      for (int l = 0; l < 8; l++) begin
        vecs[r].win[l] = 6'd32;
        vecs[r].tap[l] = 5'd16;
      end
    end
    vecs[0].err[0] = 32'hFFC0_03FF; vecs[0].win[0] = 6'd12;
    vecs[1].err[3] = 32'hFFFF_FFFF; vecs[1].win[3] = 6'd0; vecs[1].tap[3] = 5'd0;
    vecs[1].fail   = 8'h08;
    vecs[2].err[5] = 32'hFF0F_FFC3; vecs[2].win[5] = 6'd4; vecs[2].tap[5] = 5'd4;
    vecs[3].err[1] = 32'h7FFF_FFF8; vecs[3].win[1] = 6'd3; vecs[3].tap[1] = 5'd0;
    vecs[3].err[6] = 32'h0FFF_FFFF; vecs[3].win[6] = 6'd4; vecs[3].tap[6] = 5'd30;
    vecs[3].err[7] = 32'hFFFF_03E0; vecs[3].win[7] = 6'd6; vecs[3].tap[7] = 5'd13;
    vecs[3].fail   = 8'h02;

    up_rstn = 1'b0; cal_start = 1'b0; delay_locked = 1'b0;
    man_dld = '0; man_dwdata = '0; err_map = '0;
    repeat (3) cyc();
    check("rst busy", cal_busy, 0);
    check("rst done", cal_done, 0);
    check("rst fail", cal_lane_fail, 0);
    check("rst win", cal_lane_win, 0);
    check("rst clr", adc_err_clr, 0);
    check("rst dld", up_dld, 0);
    check("rst dwdata", up_dwdata, 0);
    up_rstn = 1'b1;
    cyc();

    // Manual load in IDLE
    man_dwdata[2] = 5'd13; man_dld = 8'h04;
    cyc();
    man_dld = '0;
    check("man dld", up_dld, 8'h04);
    check("man lane2", up_dwdata[2], 13);
    check("man lane1 kept", up_dwdata[1], 0);
    cyc();
    check("man dld 1 cycle", up_dld, 0);
    check("man lane2 hold", up_dwdata[2], 13);

    // Manual load with cal_start in the same cycle, then manual blocked while busy
    man_dwdata[4] = 5'd7; man_dld = 8'h10; cal_start = 1'b1;
    cyc();
    man_dld = '0; cal_start = 1'b0;
    check("start+man dld", up_dld, 8'h10);
    check("start+man lane4", up_dwdata[4], 7);
    check("start busy", cal_busy, 1);
    man_dwdata[2] = 5'd9; man_dld = 8'h04;
    cyc();
    man_dld = '0;
    check("busy man dld", up_dld, 0);
    check("busy man lane2", up_dwdata[2], 13);
    repeat (5) cyc();
    check("wait lock busy", cal_busy, 1);
    check("wait lock no dld", up_dld, 0);
    delay_locked = 1'b1;
    wait_done(nd, ns, ft, tmo);
    check("lockwait timeout", tmo, 0);
    check("lockwait done", nd, 1);
    check("lockwait strobes", ns, 33);
    check("lockwait busy end", cal_busy, 0);

    // Table of calibration vectors
    for (int r = 0; r < 4; r++) begin
      err_map = vecs[r].err;
      pulse_start();
      wait_done(nd, ns, ft, tmo);
      check($sformatf("v%0d timeout", r), tmo, 0);
      check($sformatf("v%0d done count", r), nd, 1);
      check($sformatf("v%0d fail", r), cal_lane_fail, vecs[r].fail);
      for (int l = 0; l < 8; l++) begin
        check($sformatf("v%0d win lane%0d", r, l), cal_lane_win[l], vecs[r].win[l]);
        check($sformatf("v%0d tap lane%0d", r, l), up_dwdata[l], vecs[r].tap[l]);
      end
    end

    // Lock lost during tap 7 dwell
    err_map = '0;
    pulse_start();
    n = 0; found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      cyc();
      if (up_dld == 8'hFF) begin
        n++;
        if (up_dwdata[0] == 5'd7) found = 1'b1;
      end
    end
    check("abort tap7 reached", found, 1);
    check("abort strobes before drop", n, 8);
    repeat (8) @(posedge up_clk);
    #1;
    delay_locked = 1'b0;
    repeat (3) cyc();
    check("abort busy", cal_busy, 1);
    check("abort no dld", up_dld, 0);
    delay_locked = 1'b1;
    wait_done(nd, ns, ft, tmo);
    check("abort timeout", tmo, 0);
    check("abort done", nd, 1);
    check("abort strobes", ns, 33);
    check("abort restart tap", ft, 0);
    check("abort win lane0", cal_lane_win[0], 32);

    // Reset mid-SETTLE
    err_map = vecs[0].err;
    pulse_start();
    found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      cyc();
      if (up_dld == 8'hFF && up_dwdata[0] == 5'd5) found = 1'b1;
    end
    check("rst-mid tap5 reached", found, 1);
    @(posedge up_clk);
    #2 up_rstn = 1'b0;
    #1;
    check("rst-mid busy", cal_busy, 0);
    check("rst-mid dwdata", up_dwdata, 0);
    check("rst-mid dld", up_dld, 0);
    check("rst-mid clr", adc_err_clr, 0);
    check("rst-mid done", cal_done, 0);
    check("rst-mid win", cal_lane_win, 0);
    cyc();
    up_rstn = 1'b1;
    cyc();
    pulse_start();
    wait_done(nd, ns, ft, tmo);
    check("post-rst timeout", tmo, 0);
    check("post-rst done", nd, 1);
    check("post-rst win lane0", cal_lane_win[0], 12);
    check("post-rst tap lane0", up_dwdata[0], 16);
    check("post-rst fail", cal_lane_fail, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
